// File: rtl/demux_stream.sv
// Purpose: registered 1-to-2 stream demux; each word goes to channel A (in_sel=0) or B (in_sel=1).
// Latency: a word accepted at edge N is visible on an empty output channel in cycle N+1.
// Backpressure: each channel has its own 2-entry buffer; in_ready drops only when the selected channel is full.
module demux_stream #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [WIDTH-1:0] b_data,
    output logic [1:0]       a_count,
    output logic [1:0]       b_count
);

    // Index 0 is channel A, index 1 is channel B throughout.
    logic [WIDTH-1:0] mem_q [2][2];
    logic [WIDTH-1:0] mem_d [2][2];
    logic [1:0]       wr_ptr_q, wr_ptr_d;
    logic [1:0]       rd_ptr_q, rd_ptr_d;
    logic [1:0]       cnt_q [2];
    logic [1:0]       cnt_d [2];
    logic [1:0]       push;
    logic [1:0]       pop;

    // Ready looks only at the selected channel's own count, never at the
    // consumers' ready inputs, so there is no ready-to-ready combinational path.
    assign in_ready = ((in_sel ? cnt_q[1] : cnt_q[0]) != 2'd2);

    assign push[0] = in_valid & in_ready & ~in_sel;
    assign push[1] = in_valid & in_ready &  in_sel;
    assign pop[0]  = (cnt_q[0] != 2'd0) & a_ready;
    assign pop[1]  = (cnt_q[1] != 2'd0) & b_ready;

    // Next-state for both channel buffers: write slot, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        for (int ch = 0; ch < 2; ch++) begin
            if (push[ch]) begin
                mem_d[ch][wr_ptr_q[ch]] = in_data;
                wr_ptr_d[ch]            = ~wr_ptr_q[ch];
            end
            if (pop[ch]) begin
                rd_ptr_d[ch] = ~rd_ptr_q[ch];
            end
            // Push and pop together leave the count unchanged.
            case ({push[ch], pop[ch]})
                2'b10:   cnt_d[ch] = cnt_q[ch] + 2'd1;
                2'b01:   cnt_d[ch] = cnt_q[ch] - 2'd1;
                default: cnt_d[ch] = cnt_q[ch];
            endcase
        end
    end

    // State registers; reset discards any buffered words and zeroes the data outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int ch = 0; ch < 2; ch++) begin
                for (int e = 0; e < 2; e++) begin
                    mem_q[ch][e] <= '0;
                end
                cnt_q[ch] <= 2'd0;
            end
            wr_ptr_q <= 2'b00;
            rd_ptr_q <= 2'b00;
        end else begin
            mem_q    <= mem_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Head-of-buffer outputs, all taken straight from state registers.
    assign a_valid = (cnt_q[0] != 2'd0);
    assign b_valid = (cnt_q[1] != 2'd0);
    assign a_data  = mem_q[0][rd_ptr_q[0]];
    assign b_data  = mem_q[1][rd_ptr_q[1]];
    assign a_count = cnt_q[0];
    assign b_count = cnt_q[1];

endmodule

// File: tb/tb_demux_stream.sv
// Self-checking bench for demux_stream: directed scenarios plus randomized traffic
// against a queue-based reference model of the two output channels.
module tb_demux_stream;
    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         in_sel = 1'b0;
    logic         a_valid;
    logic         a_ready = 1'b0;
    logic [W-1:0] a_data;
    logic         b_valid;
    logic         b_ready = 1'b0;
    logic [W-1:0] b_data;
    logic [1:0]   a_count;
    logic [1:0]   b_count;

    int checks = 0;
    int failures = 0;

    // Reference model: one FIFO queue per output channel.
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];

    always #5 clk = ~clk;

    demux_stream #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
        .a_count(a_count), .b_count(b_count)
    );

    function automatic bit exp_ready();
        return ((in_sel ? qb.size() : qa.size()) != 2);
    endfunction

    // Advance one clock edge and apply the same transfer to the model.
    task automatic step();
        bit pa, pb, acc;
        @(posedge clk);
        pa  = a_ready && (qa.size() != 0);
        pb  = b_ready && (qb.size() != 0);
        acc = in_valid && exp_ready();
        if (pa) void'(qa.pop_front());
        if (pb) void'(qb.pop_front());
        if (acc) begin
            if (in_sel) qb.push_back(in_data);
            else        qa.push_back(in_data);
        end
        #1;
    endtask

    // Continuous protocol monitor: count bound, no push into a full channel, held data stable.
    logic         hold_a = 1'b0, hold_b = 1'b0;
    logic [W-1:0] held_a = '0, held_b = '0;
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_a = 1'b0;
            hold_b = 1'b0;
        end else begin
            checks++;
            if (a_count > 2'd2 || b_count > 2'd2) begin
                failures++;
                $display("FAIL count_bound got a=%0d b=%0d want <=2", a_count, b_count);
            end
            if (in_valid) begin
                checks++;
                if (in_ready && ((in_sel ? b_count : a_count) == 2'd2)) begin
                    failures++;
                    $display("FAIL push_when_full got in_ready=1 want 0 (sel=%0b)", in_sel);
                end
            end
            if (hold_a) begin
                checks++;
                if (a_valid !== 1'b1 || a_data !== held_a) begin
                    failures++;
                    $display("FAIL a_stable got v=%0b d=%0h want v=1 d=%0h", a_valid, a_data, held_a);
                end
            end
            if (hold_b) begin
                checks++;
                if (b_valid !== 1'b1 || b_data !== held_b) begin
                    failures++;
                    $display("FAIL b_stable got v=%0b d=%0h want v=1 d=%0h", b_valid, b_data, held_b);
                end
            end
            hold_a = a_valid && !a_ready;
            held_a = a_data;
            hold_b = b_valid && !b_ready;
            held_b = b_data;
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if (a_valid !== 1'b0 || b_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got a=%0b b=%0b want 0 0", a_valid, b_valid);
        end
        checks++;
        if (a_count !== 2'd0 || b_count !== 2'd0) begin
            failures++;
            $display("FAIL reset_count got a=%0d b=%0d want 0 0", a_count, b_count);
        end
        checks++;
        if (a_data !== '0 || b_data !== '0) begin
            failures++;
            $display("FAIL reset_data got a=%0h b=%0h want 0 0", a_data, b_data);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got %0b want 1", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        qa.delete();
        qb.delete();
        step();
    endtask

    task automatic test_basic_steering();
        a_ready = 1'b1; b_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 64'hAAAA;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_ready got %0b want 1", in_ready);
        end
        step();
        in_sel = 1'b1; in_data = 64'hBBBB;
        @(negedge clk);
        checks++;
        if (a_valid !== 1'b1 || a_data !== 64'hAAAA || b_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_a got av=%0b ad=%0h bv=%0b want 1 aaaa 0", a_valid, a_data, b_valid);
        end
        step();
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (a_valid !== 1'b0 || b_valid !== 1'b1 || b_data !== 64'hBBBB) begin
            failures++;
            $display("FAIL basic_b got av=%0b bv=%0b bd=%0h want 0 1 bbbb", a_valid, b_valid, b_data);
        end
        step();
        @(negedge clk);
        checks++;
        if (b_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_b_once got bv=%0b want 0", b_valid);
        end
        step();
    endtask

    task automatic test_fill_backpressure();
        a_ready = 1'b0; b_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 64'h1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL fill_ready1 got %0b want 1", in_ready);
        end
        step();
        in_data = 64'h2;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || a_count !== 2'd1 || a_data !== 64'h1) begin
            failures++;
            $display("FAIL fill_second got rdy=%0b cnt=%0d d=%0h want 1 1 1", in_ready, a_count, a_data);
        end
        step();
        in_data = 64'h3;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || a_count !== 2'd2) begin
            failures++;
            $display("FAIL fill_full got rdy=%0b cnt=%0d want 0 2", in_ready, a_count);
        end
        step();
        a_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (a_data !== 64'h1 || a_count !== 2'd2 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL fill_drain1 got d=%0h cnt=%0d rdy=%0b want 1 2 0", a_data, a_count, in_ready);
        end
        step();
        @(negedge clk);
        checks++;
        if (a_data !== 64'h2 || a_count !== 2'd1 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL fill_drain2 got d=%0h cnt=%0d rdy=%0b want 2 1 1", a_data, a_count, in_ready);
        end
        step();
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (a_data !== 64'h3 || a_count !== 2'd1) begin
            failures++;
            $display("FAIL fill_third got d=%0h cnt=%0d want 3 1", a_data, a_count);
        end
        step();
        @(negedge clk);
        checks++;
        if (a_valid !== 1'b0 || a_count !== 2'd0) begin
            failures++;
            $display("FAIL fill_empty got v=%0b cnt=%0d want 0 0", a_valid, a_count);
        end
        step();
    endtask

    task automatic test_independence();
        a_ready = 1'b0; b_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 64'hA0;
        step();
        in_data = 64'hA1;
        step();
        for (int i = 0; i < 16; i++) begin
            in_sel = 1'b1;
            in_data = 64'hB00 + 64'(i);
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1 || a_count !== 2'd2) begin
                failures++;
                $display("FAIL indep_ready[%0d] got rdy=%0b acnt=%0d want 1 2", i, in_ready, a_count);
            end
            if (i > 0) begin
                checks++;
                if (b_valid !== 1'b1 || b_data !== 64'hB00 + 64'(i - 1) || b_count !== 2'd1) begin
                    failures++;
                    $display("FAIL indep_b[%0d] got v=%0b d=%0h cnt=%0d want 1 %0h 1",
                             i, b_valid, b_data, b_count, 64'hB00 + 64'(i - 1));
                end
            end
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (b_valid !== 1'b1 || b_data !== 64'hB0F || a_data !== 64'hA0) begin
            failures++;
            $display("FAIL indep_last got bv=%0b bd=%0h ad=%0h want 1 b0f a0", b_valid, b_data, a_data);
        end
        step();
        a_ready = 1'b1;
        step();
        step();
        @(negedge clk);
        checks++;
        if (a_count !== 2'd0 || b_count !== 2'd0) begin
            failures++;
            $display("FAIL indep_drain got a=%0d b=%0d want 0 0", a_count, b_count);
        end
        step();
    endtask

    task automatic test_simul_push_pop();
        a_ready = 1'b0; b_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 64'hC0;
        step();
        a_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 64'hC1 + 64'(i);
            @(negedge clk);
            checks++;
            if (a_count !== 2'd1 || in_ready !== 1'b1 || a_data !== 64'hC0 + 64'(i)) begin
                failures++;
                $display("FAIL simul[%0d] got cnt=%0d rdy=%0b d=%0h want 1 1 %0h",
                         i, a_count, in_ready, a_data, 64'hC0 + 64'(i));
            end
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (a_data !== 64'hC8 || a_count !== 2'd1) begin
            failures++;
            $display("FAIL simul_tail got d=%0h cnt=%0d want c8 1", a_data, a_count);
        end
        step();
    endtask

    task automatic test_reset_mid_stream();
        a_ready = 1'b0; b_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 64'h11;
        step();
        in_sel = 1'b1; in_data = 64'h22;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (a_count !== 2'd1 || b_count !== 2'd1) begin
            failures++;
            $display("FAIL rstmid_pre got a=%0d b=%0d want 1 1", a_count, b_count);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (a_valid !== 1'b0 || b_valid !== 1'b0 || a_count !== 2'd0 || b_count !== 2'd0) begin
            failures++;
            $display("FAIL rstmid_flush got av=%0b bv=%0b ac=%0d bc=%0d want 0 0 0 0",
                     a_valid, b_valid, a_count, b_count);
        end
        qa.delete();
        qb.delete();
        #1 rst_n = 1'b1;
        a_ready = 1'b1; b_ready = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (a_valid !== 1'b0 || b_valid !== 1'b0) begin
                failures++;
                $display("FAIL rstmid_stale[%0d] got av=%0b bv=%0b want 0 0", i, a_valid, b_valid);
            end
            step();
        end
    endtask

    task automatic test_random();
        int accepted = 0;
        int cyc = 0;
        while (accepted < 10000 && cyc < 40000) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_sel   = 1'($urandom_range(0, 1));
            in_data  = {$urandom(), $urandom()};
            a_ready  = ($urandom_range(0, 2) != 0);
            b_ready  = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            checks++;
            if (in_ready !== exp_ready()) begin
                failures++;
                $display("FAIL rnd_in_ready cyc=%0d got %0b want %0b", cyc, in_ready, exp_ready());
            end
            checks++;
            if (a_valid !== (qa.size() != 0) || a_count !== 2'(qa.size())) begin
                failures++;
                $display("FAIL rnd_a_state cyc=%0d got v=%0b cnt=%0d want cnt=%0d", cyc, a_valid, a_count, qa.size());
            end
            checks++;
            if (b_valid !== (qb.size() != 0) || b_count !== 2'(qb.size())) begin
                failures++;
                $display("FAIL rnd_b_state cyc=%0d got v=%0b cnt=%0d want cnt=%0d", cyc, b_valid, b_count, qb.size());
            end
            if (qa.size() != 0) begin
                checks++;
                if (a_data !== qa[0]) begin
                    failures++;
                    $display("FAIL rnd_a_data cyc=%0d got %0h want %0h", cyc, a_data, qa[0]);
                end
            end
            if (qb.size() != 0) begin
                checks++;
                if (b_data !== qb[0]) begin
                    failures++;
                    $display("FAIL rnd_b_data cyc=%0d got %0h want %0h", cyc, b_data, qb[0]);
                end
            end
            if (in_valid && exp_ready()) accepted++;
            cyc++;
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (accepted < 10000) begin
            failures++;
            $display("FAIL rnd_budget got accepted=%0d want 10000 within 40000 cycles", accepted);
        end
    endtask

    initial begin
        test_reset();
        test_basic_steering();
        test_fill_backpressure();
        test_independence();
        test_simul_push_pop();
        test_reset_mid_stream();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
